zero_counter_seq: RTL and testbench

Parametrised, sequential successor to the combinational zero counter. It accepts a WIDTH-bit word over a valid/ready handshake and scans it LANE bits per clock. It returns one of four counts: total zeros, total ones, leading zeros or trailing zeros. It sits behind a producer and in front of a consumer that may stall, so the result is held until it is taken.

---
 rtl/zero_counter_seq_if.sv | 27 ++
 rtl/zero_counter_seq.sv | 125 ++++++++++++
 tb/tb_zero_counter_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/zero_counter_seq_if.sv
// Handshake bundle for the sequential zero counter.
// The producer and consumer side (master) drives the word and mode and takes the result.
// The counter (slave) reports readiness, the result and its busy status.
interface zero_counter_seq_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    b;
  logic             busy;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, b, busy
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, b, busy
  );
endinterface

// File: rtl/zero_counter_seq.sv
// Sequential zero counter. It accepts a WIDTH-bit word, scans it LANE bits per
// clock starting at the LSB, and then holds the count until the consumer takes it.
// The supported counts are zeros, ones, leading zeros and trailing zeros.
// A leading-zero request is turned into a trailing-zero scan by bit-reversing
// the word when it is accepted.
module zero_counter_seq #(
  parameter int WIDTH = 8,
  parameter int LANE  = 2
) (
  input  logic          clk,
  input  logic          rst,
  zero_counter_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int N  = WIDTH / LANE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] word;
  logic [1:0]       mode_r;
  logic [IW-1:0]    idx;
  logic             stop;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    b_r;

  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] shifted;
  logic [LANE-1:0]  chunk;
  logic [CW-1:0]    add;
  logic             stop_n;
  logic [CW-1:0]    acc_n;

  assign last = (idx == IW'(N - 1));

  // State register; reset returns to IDLE and drops any in-flight word
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and handshake decode
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.b         = b_r;

  // Bit-reversed copy of the incoming word, used for leading-zero requests
  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) rev[i] = bus.a[WIDTH-1-i];
  end

  // Per-chunk contribution. The trailing-zero scan walks LSB upward and freezes at the first one.
  always_comb begin
    shifted = word >> (idx * LANE);
    chunk   = shifted[LANE-1:0];
    add     = '0;
    stop_n  = stop;
    for (int i = 0; i < LANE; i++) begin
      case (mode_r)
        2'b00: if (!chunk[i]) add = add + CW'(1);
        2'b01: if (chunk[i])  add = add + CW'(1);
        default: begin
          if (!stop_n) begin
            if (chunk[i]) stop_n = 1'b1;
            else          add    = add + CW'(1);
          end
        end
      endcase
    end
    acc_n = acc + add;
  end

  // Datapath: latch on acceptance, accumulate during SCAN, publish on the last chunk
  always_ff @(posedge clk) begin
    if (rst) begin
      word   <= '0;
      mode_r <= 2'b00;
      idx    <= '0;
      stop   <= 1'b0;
      acc    <= '0;
      b_r    <= '0;
    end else if (accept) begin
      word   <= (bus.mode == 2'b10) ? rev : bus.a;
      mode_r <= (bus.mode == 2'b10) ? 2'b11 : bus.mode;
      idx    <= '0;
      stop   <= 1'b0;
      acc    <= '0;
    end else if (state == SCAN) begin
      acc  <= acc_n;
      stop <= stop_n;
      idx  <= idx + IW'(1);
      if (last) b_r <= acc_n;
    end
  end
endmodule

// File: tb/tb_zero_counter_seq.sv
// Directed bench for zero_counter_seq: a vector table on an 8-bit/2-lane
// instance, hand-written stall/ignore/reset sequences, and a 16-bit/4-lane instance.
module tb_zero_counter_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  zero_counter_seq_if #(.WIDTH(8))  if8  ();
  zero_counter_seq_if #(.WIDTH(16)) if16 ();

  zero_counter_seq #(.WIDTH(8), .LANE(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  zero_counter_seq #(.WIDTH(16), .LANE(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [1:0] mode;
    int         exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 8-bit instance, including latency and release checks
  task automatic run8(input logic [7:0] av, input logic [1:0] m, input int exp, input string nm);
    int cyc;
    chk({nm, " in_ready"}, int'(if8.in_ready), 1);
    if8.a        = av;
    if8.mode     = m;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    if8.a        = ~av;
    if8.mode     = ~m;
    cyc = 0;
    while (!if8.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({nm, " latency"}, cyc, 4);
    chk({nm, " b"}, int'(if8.b), exp);
    chk({nm, " busy"}, int'(if8.busy), 1);
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    chk({nm, " release in_ready"}, int'(if8.in_ready), 1);
    chk({nm, " release out_valid"}, int'(if8.out_valid), 0);
  endtask

  task automatic run16(input logic [15:0] av, input logic [1:0] m, input int exp, input string nm);
    int cyc;
    if16.a        = av;
    if16.mode     = m;
    if16.in_valid = 1'b1;
    tick();
    if16.in_valid = 1'b0;
    cyc = 0;
    while (!if16.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({nm, " latency"}, cyc, 4);
    chk({nm, " b"}, int'(if16.b), exp);
    if16.out_ready = 1'b1;
    tick();
    if16.out_ready = 1'b0;
    chk({nm, " release out_valid"}, int'(if16.out_valid), 0);
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{8'h00, 2'b00, 8};
    vecs[1]  = '{8'h00, 2'b01, 0};
    vecs[2]  = '{8'h00, 2'b10, 8};
    vecs[3]  = '{8'h00, 2'b11, 8};
    vecs[4]  = '{8'hAA, 2'b00, 4};
    vecs[5]  = '{8'hAA, 2'b01, 4};
    vecs[6]  = '{8'hAA, 2'b10, 0};
    vecs[7]  = '{8'hAA, 2'b11, 1};
    vecs[8]  = '{8'h10, 2'b10, 3};
    vecs[9]  = '{8'h10, 2'b11, 4};
    vecs[10] = '{8'hFF, 2'b00, 0};
    vecs[11] = '{8'hFF, 2'b01, 8};
    vecs[12] = '{8'hFF, 2'b10, 0};
    vecs[13] = '{8'hFF, 2'b11, 0};
    vecs[14] = '{8'h81, 2'b00, 6};
    vecs[15] = '{8'h06, 2'b11, 1};

    if8.in_valid   = 1'b0;
    if8.a          = '0;
    if8.mode       = 2'b00;
    if8.out_ready  = 1'b0;
    if16.in_valid  = 1'b0;
    if16.a         = '0;
    if16.mode      = 2'b00;
    if16.out_ready = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset in_ready", int'(if8.in_ready), 1);
    chk("reset out_valid", int'(if8.out_valid), 0);
    chk("reset b", int'(if8.b), 0);
    chk("reset busy", int'(if8.busy), 0);

    // Table of single transactions
    for (int i = 0; i < 16; i++)
      run8(vecs[i].a, vecs[i].mode, vecs[i].exp, $sformatf("vec%0d", i));

    // Consumer stalls for 5 cycles; the result must hold
    if8.a        = 8'hFF;
    if8.mode     = 2'b00;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    cyc = 0;
    while (!if8.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("stall latency", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d b", i), int'(if8.b), 0);
      chk($sformatf("stall%0d out_valid", i), int'(if8.out_valid), 1);
      chk($sformatf("stall%0d in_ready", i), int'(if8.in_ready), 0);
      chk($sformatf("stall%0d busy", i), int'(if8.busy), 1);
    end
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    chk("stall release in_ready", int'(if8.in_ready), 1);
    chk("stall release busy", int'(if8.busy), 0);

    // New word and mode offered during SCAN/DONE must be ignored, including at release
    if8.a        = 8'h01;
    if8.mode     = 2'b11;
    if8.in_valid = 1'b1;
    tick();
    if8.a    = 8'h00;
    if8.mode = 2'b00;
    cyc = 0;
    while (!if8.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("ignore latency", cyc, 4);
    chk("ignore b", int'(if8.b), 0);
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    chk("ignore release in_ready", int'(if8.in_ready), 1);
    chk("ignore release busy", int'(if8.busy), 0);
    if8.in_valid = 1'b0;

    // Reset on the second SCAN cycle
    run8(8'h00, 2'b00, 8, "prerst");
    if8.a        = 8'h00;
    if8.mode     = 2'b00;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst scan in_ready", int'(if8.in_ready), 1);
    chk("rst scan out_valid", int'(if8.out_valid), 0);
    chk("rst scan b", int'(if8.b), 0);
    chk("rst scan busy", int'(if8.busy), 0);
    repeat (6) tick();
    chk("rst scan no result", int'(if8.out_valid), 0);

    // Reset while holding a result in DONE
    if8.a        = 8'h00;
    if8.mode     = 2'b00;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    cyc = 0;
    while (!if8.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("rst done b before", int'(if8.b), 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst done in_ready", int'(if8.in_ready), 1);
    chk("rst done out_valid", int'(if8.out_valid), 0);
    chk("rst done b", int'(if8.b), 0);
    chk("rst done busy", int'(if8.busy), 0);
    run8(8'h81, 2'b00, 6, "postrst");

    // Wider instance
    run16(16'h0000, 2'b00, 16, "w16 zeros");
    run16(16'h8000, 2'b11, 15, "w16 tz");
    run16(16'h8000, 2'b10, 0, "w16 lz");
    run16(16'hFFFF, 2'b01, 16, "w16 ones");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
